// File: rtl/decode_queue_pkg.sv
// Shared opcode constants and control-field type for the decode queue.
package decode_queue_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_J    = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_JR   = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_JAL  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_JALR = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_SLBI = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_STU  = 5'b10011;
  localparam logic [OPC_W-1:0] OPC_LBI  = 5'b11000;

  // Three-bit opcode prefixes that select whole groups.
  localparam logic [2:0] PFX_JUMP = 3'b001;
  localparam logic [2:0] PFX_BR   = 3'b011;
  localparam logic [2:0] PFX_I1   = 3'b010;
  localparam logic [2:0] PFX_I2   = 3'b101;

  // JAL/JALR write the return address here.
  localparam logic [2:0] LINK_REG = 3'd7;

  typedef struct packed {
    logic reg_write;
    logic mem_rd;
    logic mem_wr;
    logic branch;
    logic jump;
    logic halt;
  } ctrl_t;

endpackage

// File: rtl/decode_queue_instr_fifo.sv
// Circular instruction/PC store with occupancy count and synchronous flush.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wptr, rptr;
  logic                        do_push, do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push & (count != CNT_W'(DEPTH));
  assign do_pop  = pop  & (count != '0);
  assign rdata   = mem[rptr];

  // Storage array; contents need no reset since count qualifies them.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wptr] <= wdata;
  end

  // Pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Fetch-side instruction queue with head decode into a valid/ready output register.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  input  logic               haz_stall,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [2:0]         out_rs,
  output logic [2:0]         out_rt,
  output logic [2:0]         out_rd,
  output logic               out_reg_write,
  output logic               out_mem_rd,
  output logic               out_mem_wr,
  output logic               out_branch,
  output logic               out_jump,
  output logic               out_halt,
  output logic               halted,
  output logic [CNT_W-1:0]   count
);

  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_pc;
  logic               push, load;
  logic [OPC_W-1:0]   opc;
  logic [2:0]         dec_rd;
  ctrl_t              dec_ctrl;

  // No pop-through: a full queue refuses even when the head leaves this cycle.
  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid & in_ready & ~flush;
  assign load     = (count != '0) & ~haz_stall & ~halted & ~flush &
                    (~out_valid | out_ready);

  instr_fifo #(
    .WIDTH (PC_W + INSTR_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (load),
    .wdata ({in_pc, in_instr}),
    .rdata ({head_pc, head_instr}),
    .count (count)
  );

  assign opc = head_instr[INSTR_W-1 -: OPC_W];

  // Destination register select and control bits for the queue head.
  always_comb begin
    dec_rd = head_instr[4:2];
    if (opc[4:2] == PFX_I1 || opc[4:2] == PFX_I2 || opc == OPC_LD || opc == OPC_STU)
      dec_rd = head_instr[7:5];
    else if (opc == OPC_SLBI || opc == OPC_LBI)
      dec_rd = head_instr[10:8];
    else if (opc == OPC_JAL || opc == OPC_JALR)
      dec_rd = LINK_REG;

    dec_ctrl           = '0;
    dec_ctrl.reg_write = !(opc == OPC_HALT || opc == OPC_NOP || opc == OPC_J ||
                           opc == OPC_JR   || opc == OPC_ST  || opc[4:2] == PFX_BR);
    dec_ctrl.mem_wr    = (opc == OPC_ST) || (opc == OPC_STU);
    dec_ctrl.mem_rd    = (opc == OPC_LD);
    dec_ctrl.branch    = (opc[4:2] == PFX_BR);
    dec_ctrl.jump      = (opc[4:2] == PFX_JUMP);
    dec_ctrl.halt      = (opc == OPC_HALT);
  end

  // Output register: flush beats load, load beats drain; stall freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_instr     <= '0;
      out_pc        <= '0;
      out_rs        <= '0;
      out_rt        <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_rd    <= 1'b0;
      out_mem_wr    <= 1'b0;
      out_branch    <= 1'b0;
      out_jump      <= 1'b0;
      out_halt      <= 1'b0;
      halted        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_instr     <= head_instr;
      out_pc        <= head_pc;
      out_rs        <= head_instr[10:8];
      out_rt        <= head_instr[7:5];
      out_rd        <= dec_rd;
      out_reg_write <= dec_ctrl.reg_write;
      out_mem_rd    <= dec_ctrl.mem_rd;
      out_mem_wr    <= dec_ctrl.mem_wr;
      out_branch    <= dec_ctrl.branch;
      out_jump      <= dec_ctrl.jump;
      out_halt      <= dec_ctrl.halt;
      if (dec_ctrl.halt) halted <= 1'b1;
    end else if (out_valid && out_ready && !haz_stall) begin
      out_valid <= 1'b0;
    end
  end

endmodule
